// File: rtl/gpio_trace_pkg.sv
// Shared types for the GPIO trace capture block.
//
// Contents:
//   state_e     capture FSM states (IDLE, ARM, RUN)
//   event_t     {timestamp, value} record at the default widths (24-bit ts, 4-bit value)
//   make_event  packs a timestamp and a sampled value into an event_t
//
// The top module rebuilds the same layout at its own parameterised widths.
// event_t stays here so that consumers of the default build share one record definition.
package gpio_trace_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam int unsigned EVT_TS_W   = 24;
  localparam int unsigned EVT_DATA_W = 4;

  typedef struct packed {
    logic [EVT_TS_W-1:0]   ts;
    logic [EVT_DATA_W-1:0] value;
  } event_t;

  function automatic event_t make_event(input logic [EVT_TS_W-1:0]   ts,
                                        input logic [EVT_DATA_W-1:0] value);
    event_t evt;
    evt.ts    = ts;
    evt.value = value;
    return evt;
  endfunction

endpackage

// File: rtl/gpio_trace_fifo.sv
// Synchronous FIFO holding trace events.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   clear_i          synchronous flush; wins over push and pop
//   push_i           write push_data_i if not full, or if a pop happens in the same cycle
//   pop_i            consumer ready; pops only when the FIFO is not empty
//   head_o           storage slot at the read pointer (combinational)
//   full_o, empty_o  occupancy flags
//   level_o          current number of entries
//
// The pointers carry one extra MSB, so full and empty are both distinguishable.
// DEPTH must be a power of 2 so that the pointers wrap naturally.
module gpio_trace_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // An empty FIFO never bypasses: a push into an empty FIFO with pop_i high is written and not popped.
  assign do_pop  = pop_i && !empty_o && !clear_i;
  assign do_push = push_i && (!full_o || do_pop) && !clear_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q[AW-1:0]] = push_data_i;
        wr_ptr_d                = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end
  end

  // Storage is reset too, so that the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/gpio_trace_capture.sv
// GPIO trace capture: timestamps every change of a GPIO vector into an on-chip FIFO.
// Events are read out over a valid/ready port.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   enable_i        capture enable; a rising edge arms capture (initial event {0, value})
//   clear_i         flushes the FIFO and clears overflow_o, dropped_o and the watchdog flag
//   data_i          monitored vector; it is synchronised internally
//   evt_valid_o     FIFO head valid
//   evt_ready_i     consumer accepts the head
//   evt_data_o      {timestamp, value} at the FIFO head
//   level_o         FIFO occupancy
//   overflow_o      sticky flag: an event was dropped
//   dropped_o       saturating count of dropped events
//   wdg_timeout_o   watchdog flag
//
// Optional feature: define GPIO_TRACE_WATCHDOG_EN to build a watchdog.
// It raises wdg_timeout_o after WDG_TICKS timestamp ticks in RUN without an event.
// Without the macro, wdg_timeout_o is tied low.
module gpio_trace_capture
  import gpio_trace_pkg::*;
#(
  parameter int DATA_W   = 4,
  parameter int DEPTH    = 16,
  parameter int TS_W     = 24,
  parameter int PRESCALE = 50,
  parameter int DROP_W   = 16
`ifdef GPIO_TRACE_WATCHDOG_EN
  ,
  parameter int WDG_TICKS = 1000
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable_i,
  input  logic                   clear_i,
  input  logic [DATA_W-1:0]      data_i,
  output logic                   evt_valid_o,
  input  logic                   evt_ready_i,
  output logic [TS_W+DATA_W-1:0] evt_data_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   overflow_o,
  output logic [DROP_W-1:0]      dropped_o,
  output logic                   wdg_timeout_o
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [DATA_W-1:0] value;
  } trace_evt_t;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  sync1_q, sync2_q;
  logic [DATA_W-1:0]  prev_q, prev_d;
  logic [TS_W-1:0]    ts_q, ts_d, push_ts;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic               overflow_q, overflow_d;
  logic [DROP_W-1:0]  dropped_q, dropped_d;
  logic               push_req, tick, drop;
  logic               fifo_full, fifo_empty;
  trace_evt_t         push_evt;

  // Two-flop synchroniser; the logic below looks only at sync2_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= data_i;
      sync2_q <= sync1_q;
    end
  end

  assign tick = (state_q == RUN) && (pre_q == PRE_LAST);

  // ARM forces the first log entry. RUN logs every change and advances the saturating timestamp.
  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    ts_d     = ts_q;
    pre_d    = pre_q;
    push_req = 1'b0;
    push_ts  = ts_q;
    case (state_q)
      IDLE: begin
        if (enable_i) state_d = ARM;
      end
      ARM: begin
        ts_d     = '0;
        pre_d    = '0;
        prev_d   = sync2_q;
        push_req = 1'b1;
        push_ts  = '0;
        state_d  = RUN;
      end
      RUN: begin
        if (tick) begin
          pre_d = '0;
          if (ts_q != '1) ts_d = ts_q + 1'b1;
        end else begin
          pre_d = pre_q + 1'b1;
        end
        if (sync2_q != prev_q) begin
          push_req = 1'b1;
          prev_d   = sync2_q;
        end
        if (!enable_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign push_evt = '{ts: push_ts, value: sync2_q};

  // A push is dropped only when the FIFO is full and no pop frees a slot in the same cycle.
  assign drop = push_req && fifo_full && !evt_ready_i && !clear_i;

  always_comb begin
    overflow_d = overflow_q;
    dropped_d  = dropped_q;
    if (clear_i) begin
      overflow_d = 1'b0;
      dropped_d  = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (dropped_q != '1) dropped_d = dropped_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prev_q     <= '0;
      ts_q       <= '0;
      pre_q      <= '0;
      overflow_q <= 1'b0;
      dropped_q  <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      ts_q       <= ts_d;
      pre_q      <= pre_d;
      overflow_q <= overflow_d;
      dropped_q  <= dropped_d;
    end
  end

  gpio_trace_fifo #(
    .WIDTH(TS_W + DATA_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (clear_i),
    .push_i     (push_req),
    .push_data_i(push_evt),
    .pop_i      (evt_ready_i),
    .head_o     (evt_data_o),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .level_o    (level_o)
  );

  assign evt_valid_o = !fifo_empty;
  assign overflow_o  = overflow_q;
  assign dropped_o   = dropped_q;

`ifdef GPIO_TRACE_WATCHDOG_EN
  localparam int WDG_W = $clog2(WDG_TICKS + 1);
  localparam logic [WDG_W-1:0] WDG_LIMIT = WDG_W'(WDG_TICKS);

  logic [WDG_W-1:0] wdg_cnt_q, wdg_cnt_d;
  logic             wdg_flag_q, wdg_flag_d;

  // Counts ticks since the last pushed or dropped event. The flag sets only on the cycle
  // the count first reaches the limit, so a clear is not immediately undone by a saturated count.
  always_comb begin
    wdg_cnt_d  = wdg_cnt_q;
    wdg_flag_d = wdg_flag_q;
    if (state_q == ARM || (state_q == RUN && push_req)) begin
      wdg_cnt_d = '0;
    end else if (tick && wdg_cnt_q != WDG_LIMIT) begin
      wdg_cnt_d = wdg_cnt_q + 1'b1;
    end
    if (clear_i) begin
      wdg_flag_d = 1'b0;
    end else if (wdg_cnt_d == WDG_LIMIT && wdg_cnt_q != WDG_LIMIT) begin
      wdg_flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdg_cnt_q  <= '0;
      wdg_flag_q <= 1'b0;
    end else begin
      wdg_cnt_q  <= wdg_cnt_d;
      wdg_flag_q <= wdg_flag_d;
    end
  end

  assign wdg_timeout_o = wdg_flag_q;
`else
  assign wdg_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_trace_capture.sv
// Testbench for gpio_trace_capture.
// The DUT is built with DEPTH=4, TS_W=4 and PRESCALE=1, so the timestamp advances once per
// RUN cycle and saturates at 15. It also uses WDG_TICKS=8 when GPIO_TRACE_WATCHDOG_EN is defined.
module tb_gpio_trace_capture;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable_i;
  logic       clear_i;
  logic [3:0] data_i;
  logic       evt_valid_o;
  logic       evt_ready_i;
  logic [7:0] evt_data_o;
  logic [2:0] level_o;
  logic       overflow_o;
  logic [15:0] dropped_o;
  logic       wdg_timeout_o;

  int checks   = 0;
  int failures = 0;

  gpio_trace_capture #(
    .DATA_W  (4),
    .DEPTH   (4),
    .TS_W    (4),
    .PRESCALE(1),
    .DROP_W  (16)
`ifdef GPIO_TRACE_WATCHDOG_EN
    ,
    .WDG_TICKS(8)
`endif
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_i     (enable_i),
    .clear_i      (clear_i),
    .data_i       (data_i),
    .evt_valid_o  (evt_valid_o),
    .evt_ready_i  (evt_ready_i),
    .evt_data_o   (evt_data_o),
    .level_o      (level_o),
    .overflow_o   (overflow_o),
    .dropped_o    (dropped_o),
    .wdg_timeout_o(wdg_timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  data;
    logic        ready;
    logic        clear;
    logic        exp_valid;
    logic [2:0]  exp_level;
    logic [7:0]  exp_head;
    logic        exp_ovf;
    logic [15:0] exp_drop;
  } row_t;

  row_t       rows[$];
  logic [3:0] exp_q[$];
  logic [3:0] cur;
  logic       exp_wdg;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input row_t r);
    data_i      = r.data;
    evt_ready_i = r.ready;
    clear_i     = r.clear;
  endtask

  task automatic addRow(input logic [3:0] d, input logic rdy, input logic clr, input logic v,
                        input logic [2:0] lvl, input logic [7:0] head, input logic ovf,
                        input logic [15:0] drp);
    row_t r;
    r.data = d; r.ready = rdy; r.clear = clr; r.exp_valid = v;
    r.exp_level = lvl; r.exp_head = head; r.exp_ovf = ovf; r.exp_drop = drp;
    rows.push_back(r);
  endtask

  // Called with inputs already set for the coming edge: if a pop will happen, check it against the scoreboard.
  task automatic observePop();
    if (evt_valid_o && evt_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL rand unexpected pop: actual=%0h required=none", evt_data_o);
      end else begin
        checkOutput("rand head", {24'h0, evt_data_o}, {24'h0, 4'hF, exp_q[0]});
        void'(exp_q.pop_front());
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global timeout: actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Table rows start right after the arm edge a+2. Row n is applied before edge a+n (n = 3..35).
    // A change applied before edge k reaches sync after k+1 and is pushed at k+2, carrying
    // the ts from after k+1. With PRESCALE=1 that ts is n, saturating at 15.
    //     data  rdy clr  valid lvl head  ovf drop
    addRow(4'h5, 1, 0,   0, 0, 8'h00, 0, 0);  // 3: pop the arm event
    addRow(4'hA, 0, 0,   0, 0, 8'h00, 0, 0);  // 4: change to A
    addRow(4'hA, 0, 0,   0, 0, 8'h00, 0, 0);  // 5: still in synchroniser
    addRow(4'hA, 0, 0,   1, 1, 8'h5A, 0, 0);  // 6: k+2 -> {5,A}
    addRow(4'hA, 0, 1,   0, 0, 8'h00, 0, 0);  // 7: clear
    addRow(4'h1, 0, 0,   0, 0, 8'h00, 0, 0);  // 8
    addRow(4'h2, 0, 0,   0, 0, 8'h00, 0, 0);  // 9
    addRow(4'h3, 0, 0,   1, 1, 8'h91, 0, 0);  // 10
    addRow(4'h4, 0, 0,   1, 2, 8'h91, 0, 0);  // 11
    addRow(4'h6, 0, 0,   1, 3, 8'h91, 0, 0);  // 12
    addRow(4'h7, 0, 0,   1, 4, 8'h91, 0, 0);  // 13: full
    addRow(4'h8, 0, 0,   1, 4, 8'h91, 1, 1);  // 14: drop 6
    addRow(4'h8, 0, 0,   1, 4, 8'h91, 1, 2);  // 15: drop 7
    addRow(4'h8, 0, 0,   1, 4, 8'h91, 1, 3);  // 16: drop 8
    addRow(4'h8, 0, 0,   1, 4, 8'h91, 1, 3);  // 17: prev followed the drops
    addRow(4'h8, 0, 1,   0, 0, 8'h00, 0, 0);  // 18: clear
    addRow(4'h9, 0, 0,   0, 0, 8'h00, 0, 0);  // 19
    addRow(4'hB, 0, 0,   0, 0, 8'h00, 0, 0);  // 20
    addRow(4'hC, 0, 0,   1, 1, 8'hF9, 0, 0);  // 21: ts saturated at 15
    addRow(4'hD, 0, 0,   1, 2, 8'hF9, 0, 0);  // 22
    addRow(4'hE, 0, 0,   1, 3, 8'hF9, 0, 0);  // 23
    addRow(4'hE, 0, 0,   1, 4, 8'hF9, 0, 0);  // 24: full
    addRow(4'hE, 1, 0,   1, 4, 8'hFB, 0, 0);  // 25: push E + pop 9 together
    addRow(4'hE, 1, 0,   1, 3, 8'hFC, 0, 0);  // 26
    addRow(4'hE, 1, 0,   1, 2, 8'hFD, 0, 0);  // 27
    addRow(4'hE, 1, 0,   1, 1, 8'hFE, 0, 0);  // 28
    addRow(4'hE, 1, 0,   0, 0, 8'h00, 0, 0);  // 29
    addRow(4'hE, 1, 0,   0, 0, 8'h00, 0, 0);  // 30: ready on empty
    addRow(4'h3, 1, 0,   0, 0, 8'h00, 0, 0);  // 31
    addRow(4'h3, 1, 0,   0, 0, 8'h00, 0, 0);  // 32
    addRow(4'h3, 1, 0,   1, 1, 8'hF3, 0, 0);  // 33: push into empty with ready, no bypass
    addRow(4'h3, 0, 0,   1, 1, 8'hF3, 0, 0);  // 34
    addRow(4'h3, 1, 0,   0, 0, 8'h00, 0, 0);  // 35

    rst_n = 1'b1; enable_i = 1'b0; clear_i = 1'b0; evt_ready_i = 1'b0; data_i = 4'h5;
    #2 rst_n = 1'b0;
    #10;
    checkOutput("reset valid", {31'h0, evt_valid_o}, 32'h0);
    checkOutput("reset data", {24'h0, evt_data_o}, 32'h0);
    checkOutput("reset level", {29'h0, level_o}, 32'h0);
    checkOutput("reset overflow", {31'h0, overflow_o}, 32'h0);
    checkOutput("reset dropped", {16'h0, dropped_o}, 32'h0);
    checkOutput("reset wdg", {31'h0, wdg_timeout_o}, 32'h0);

    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) tick();
    checkOutput("idle no arm", {29'h0, level_o}, 32'h0);

    // Boot arm: ARM at the first edge, {0,5} pushed at the second edge.
    enable_i = 1'b1;
    repeat (4) tick();
    checkOutput("arm valid", {31'h0, evt_valid_o}, 32'h1);
    checkOutput("arm level", {29'h0, level_o}, 32'h1);
    checkOutput("arm data", {24'h0, evt_data_o}, 32'h05);

    for (int i = 0; i < rows.size(); i++) begin
      applyStimulus(rows[i]);
      tick();
      checkOutput($sformatf("row%0d valid", i + 3), {31'h0, evt_valid_o}, {31'h0, rows[i].exp_valid});
      checkOutput($sformatf("row%0d level", i + 3), {29'h0, level_o}, {29'h0, rows[i].exp_level});
      checkOutput($sformatf("row%0d overflow", i + 3), {31'h0, overflow_o}, {31'h0, rows[i].exp_ovf});
      checkOutput($sformatf("row%0d dropped", i + 3), {16'h0, dropped_o}, {16'h0, rows[i].exp_drop});
      if (rows[i].exp_valid)
        checkOutput($sformatf("row%0d head", i + 3), {24'h0, evt_data_o}, {24'h0, rows[i].exp_head});
    end

    // Random backpressure against a scoreboard. At most three events are outstanding, so none are dropped.
    cur = 4'h3;
    clear_i = 1'b0;
    for (int c = 0; c < 240; c++) begin
      evt_ready_i = ($urandom_range(0, 1) == 1);
      if ((c % 3) == 0 && exp_q.size() <= 2) begin
        cur    = cur ^ 4'($urandom_range(1, 15));
        data_i = cur;
        exp_q.push_back(cur);
      end
      observePop();
      tick();
    end
    evt_ready_i = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      observePop();
      tick();
    end
    checkOutput("rand leftover", exp_q.size(), 32'h0);
    checkOutput("rand level", {29'h0, level_o}, 32'h0);
    checkOutput("rand overflow", {31'h0, overflow_o}, 32'h0);

    // Watchdog: a change pushed at k+2 restarts the count, and the flag rises after k+10.
    evt_ready_i = 1'b0;
    cur = cur ^ 4'h1;
    data_i = cur;
    repeat (3) tick();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    checkOutput("wdg clear level", {29'h0, level_o}, 32'h0);
    checkOutput("wdg cleared", {31'h0, wdg_timeout_o}, 32'h0);
    repeat (6) tick();
    checkOutput("wdg before limit", {31'h0, wdg_timeout_o}, 32'h0);
    tick();
`ifdef GPIO_TRACE_WATCHDOG_EN
    exp_wdg = 1'b1;
`else
    exp_wdg = 1'b0;
`endif
    checkOutput("wdg at limit", {31'h0, wdg_timeout_o}, {31'h0, exp_wdg});

    // Asynchronous reset in the middle of RUN, with an event in the FIFO.
    cur = cur ^ 4'h2;
    data_i = cur;
    repeat (3) tick();
    checkOutput("pre-reset level", {29'h0, level_o}, 32'h1);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async rst valid", {31'h0, evt_valid_o}, 32'h0);
    checkOutput("async rst data", {24'h0, evt_data_o}, 32'h0);
    checkOutput("async rst level", {29'h0, level_o}, 32'h0);
    checkOutput("async rst overflow", {31'h0, overflow_o}, 32'h0);
    checkOutput("async rst dropped", {16'h0, dropped_o}, 32'h0);
    checkOutput("async rst wdg", {31'h0, wdg_timeout_o}, 32'h0);
    enable_i = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (6) tick();
    checkOutput("post-reset idle level", {29'h0, level_o}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
